// File: rtl/mem_resp_stage.sv
// Memory-response pipeline stage: waits for in-order data_sram responses, buffers
// early data, and discards responses that belong to flushed requests.
module mem_resp_stage #(
  parameter int EXC_W = 6,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ws_allowin,
  output logic               ms_allowin,
  input  logic               es_to_ms_valid,
  input  logic [75+EXC_W:0]  es_to_ms_bus,
  output logic               ms_to_ws_valid,
  output logic [69+EXC_W:0]  ms_to_ws_bus,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata,
  input  logic               flush,
  input  logic               es_req_cancel,
  output logic [38:0]        ms_fwd_bus,
  output logic [2:0]         ms_cancel_cnt,
  output logic               ms_cancel_full
);

  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  logic              r_ms_valid;
  logic [75+EXC_W:0] r_bus;
  logic              r_rbuf_valid;
  logic [31:0]       r_rbuf_data;
  logic [2:0]        r_cancel_cnt;

  logic [31:0]       w_pc;
  logic [31:0]       w_alu;
  logic [4:0]        w_dest;
  logic              w_gr_we;
  logic [4:0]        w_load_op;
  logic              w_req_issued;
  logic [EXC_W-1:0]  w_exc;

  logic              w_cnt_zero;
  logic              w_have_data;
  logic              w_ready_go;
  logic              w_leave;
  logic              w_discard;
  logic              w_rbuf_load;
  logic              w_ms_wait;
  logic [3:0]        w_cnt_sum;
  logic [2:0]        w_cnt_next;
  logic [31:0]       w_ld_src;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_val;
  logic [31:0]       w_final;

  assign w_pc         = r_bus[31:0];
  assign w_alu        = r_bus[63:32];
  assign w_dest       = r_bus[68:64];
  assign w_gr_we      = r_bus[69];
  assign w_load_op    = r_bus[74:70];
  assign w_req_issued = r_bus[75];
  assign w_exc        = r_bus[75+EXC_W:76];

  // A response only belongs to the MS instruction once all discards are drained.
  assign w_cnt_zero  = (r_cancel_cnt == 3'd0);
  assign w_discard   = data_sram_data_ok & ~w_cnt_zero;
  assign w_have_data = r_rbuf_valid | (data_sram_data_ok & w_cnt_zero);
  assign w_ready_go  = ~w_req_issued | w_have_data;

  assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_ms_valid & w_ready_go & ~flush;
  assign w_leave        = ms_to_ws_valid & ws_allowin;
  assign w_ms_wait      = r_ms_valid & w_req_issued & ~w_have_data;
  assign w_rbuf_load    = data_sram_data_ok & w_cnt_zero & r_ms_valid & w_req_issued &
                          ~r_rbuf_valid & ~ws_allowin;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_cnt_sum  = {1'b0, r_cancel_cnt} + 4'(w_ms_wait) + 4'(es_req_cancel) - 4'(w_discard);
    w_cnt_next = r_cancel_cnt;
    if (flush) begin
      w_cnt_next = (w_cnt_sum > DEPTH_W) ? DEPTH_W[2:0] : w_cnt_sum[2:0];
    end else if (w_discard) begin
      w_cnt_next = r_cancel_cnt - 3'd1;
    end
  end

  assign w_ld_src = r_rbuf_valid ? r_rbuf_data : data_sram_rdata;
  assign w_byte   = w_ld_src[{w_alu[1:0], 3'b000} +: 8];
  assign w_half   = w_ld_src[{w_alu[1], 4'b0000} +: 16];

  always_comb begin
    w_load_val = w_ld_src;
    if (w_load_op[4])      w_load_val = {{24{w_byte[7]}}, w_byte};
    else if (w_load_op[3]) w_load_val = {{16{w_half[15]}}, w_half};
    else if (w_load_op[1]) w_load_val = {24'd0, w_byte};
    else if (w_load_op[0]) w_load_val = {16'd0, w_half};
  end

  assign w_final = ((|w_exc) || (w_load_op == 5'd0)) ? w_alu : w_load_val;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid   <= 1'b0;
      r_rbuf_valid <= 1'b0;
      r_cancel_cnt <= 3'd0;
    end else begin
      if (flush)           r_ms_valid <= 1'b0;
      else if (ms_allowin) r_ms_valid <= es_to_ms_valid;

      if (flush)            r_rbuf_valid <= 1'b0;
      else if (w_leave)     r_rbuf_valid <= 1'b0;
      else if (w_rbuf_load) r_rbuf_valid <= 1'b1;

      r_cancel_cnt <= w_cnt_next;
    end
  end

  // NOTE: payload registers are not reset; they are only observed under their valid bits.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) r_bus <= es_to_ms_bus;
    if (w_rbuf_load) r_rbuf_data <= data_sram_rdata;
  end

  assign ms_to_ws_bus   = {w_exc, w_gr_we, w_dest, w_final, w_pc};
  assign ms_fwd_bus     = {r_ms_valid & w_gr_we,
                           r_ms_valid & w_gr_we & (|w_load_op) & ~w_have_data,
                           w_dest, w_final};
  assign ms_cancel_cnt  = r_cancel_cnt;
  assign ms_cancel_full = ({1'b0, r_cancel_cnt} == DEPTH_W);

endmodule

// File: tb/tb_mem_resp_stage.sv
// Scoreboard bench for mem_resp_stage: an in-order memory model tags each request
// with its data; a monitor pops expected WB payloads whenever MS hands one over.
module tb_mem_resp_stage;
  localparam int EXC_W = 6;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [EXC_W-1:0] exc;
    logic             req;
    logic [4:0]       lop;
    logic             we;
    logic [4:0]       dest;
    logic [31:0]      alu;
    logic [31:0]      pc;
  } ins_t;

  // Request lifecycle: issued from EX, owned by MS, or killed by a flush.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  st;
  } mreq_t;
  localparam logic [1:0] ST_EX = 2'd0, ST_MS = 2'd1, ST_KILL = 2'd2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              ws_allowin;
  logic              ms_allowin;
  logic              es_to_ms_valid;
  logic [75+EXC_W:0] es_to_ms_bus;
  logic              ms_to_ws_valid;
  logic [69+EXC_W:0] ms_to_ws_bus;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              flush;
  logic              es_req_cancel;
  logic [38:0]       ms_fwd_bus;
  logic [2:0]        ms_cancel_cnt;
  logic              ms_cancel_full;

  mem_resp_stage #(.EXC_W(EXC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .es_req_cancel(es_req_cancel), .ms_fwd_bus(ms_fwd_bus),
    .ms_cancel_cnt(ms_cancel_cnt), .ms_cancel_full(ms_cancel_full)
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                failures = 0;
  mreq_t             mem_q[$];
  logic [69+EXC_W:0] exp_q[$];
  bit                dir_chk = 1'b0;
  logic [31:0]       dir_exp;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic int killed();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].st == ST_KILL) n++;
    return n;
  endfunction

  // Architectural meaning of a load: pick the addressed lane, then extend.
  function automatic logic [69+EXC_W:0] ref_out(input ins_t i, input logic [31:0] d);
    logic [31:0] res, b, h;
    b   = (d >> (8 * int'(i.alu[1:0]))) & 32'hFF;
    h   = (d >> (16 * int'(i.alu[1]))) & 32'hFFFF;
    res = i.alu;
    if (i.exc == '0) begin
      case (i.lop)
        5'b10000: res = (b >= 128) ? b - 256 : b;
        5'b01000: res = (h >= 32768) ? h - 65536 : h;
        5'b00100: res = d;
        5'b00010: res = b;
        5'b00001: res = h;
        default:  res = i.alu;
      endcase
    end
    return {i.exc, i.we, i.dest, res, i.pc};
  endfunction

  initial begin : monitor
    logic [69+EXC_W:0] e;
    forever begin
      @(negedge clk);
      if (resetn && ms_to_ws_valid && ws_allowin) begin
        check("output_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wb_bus", ms_to_ws_bus, e);
          if (dir_chk) begin
            check("dir_result", ms_to_ws_bus[63:32], dir_exp);
            dir_chk = 1'b0;
          end
        end
      end
    end
  end

  // One clock of stimulus: drive after the edge, update the model at the falling edge.
  task automatic step(input bit v, input ins_t ins, input logic [31:0] mdata, input bit issue,
                      input bit ws, input bit fl, input bit dok, output bit hs);
    int k;
    if (issue) mem_q.push_back('{data: mdata, st: ST_EX});
    es_to_ms_valid    = v;
    es_to_ms_bus      = ins;
    ws_allowin        = ws;
    flush             = fl;
    es_req_cancel     = fl & v & ins.req;
    data_sram_data_ok = dok;
    data_sram_rdata   = (dok && mem_q.size() > 0) ? mem_q[0].data : $urandom;
    @(negedge clk);
    hs = v && ms_allowin && !fl;
    if (dok && mem_q.size() > 0) mem_q.delete(0);
    if (fl) begin
      foreach (mem_q[i]) mem_q[i].st = ST_KILL;
      exp_q.delete();
    end else if (hs) begin
      if (ins.req) foreach (mem_q[i]) if (mem_q[i].st == ST_EX) mem_q[i].st = ST_MS;
      exp_q.push_back(ref_out(ins, mdata));
    end
    @(posedge clk);
    #1;
    k = killed();
    check("cancel_cnt", ms_cancel_cnt, 3'(k));
    check("cancel_full", ms_cancel_full, k == DEPTH);
    check("fwd_we", ms_fwd_bus[38], exp_q.size() > 0 && exp_q[0][69]);
  endtask

  initial begin : stimulus
    bit          hs, pres, issue, dok;
    ins_t        ins, pins;
    logic [31:0] pdat;
    int          r;

    resetn = 1'b1;
    ws_allowin = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; flush = 1'b0;
    es_req_cancel = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", ms_to_ws_valid, 1'b0);
    check("rst_cnt", ms_cancel_cnt, 3'd0);
    check("rst_full", ms_cancel_full, 1'b0);
    check("rst_fwd", ms_fwd_bus[38:37], 2'b00);
    resetn = 1'b1;

    // ld.b from byte 3: sign-extended 0x80, delivered on the data_ok cycle.
    ins = '0; ins.lop = 5'b10000; ins.req = 1'b1; ins.we = 1'b1; ins.dest = 5'd3;
    ins.alu = 32'h0000_1003; ins.pc = 32'h1c00_0000;
    step(1, ins, 32'h80FF_FF00, 1, 1, 0, 0, hs);
    check("t033_accept", hs, 1'b1);
    check("t033_wait", ms_to_ws_valid, 1'b0);
    check("t033_pending", ms_fwd_bus[37], 1'b1);
    dir_exp = 32'hFFFF_FF80; dir_chk = 1'b1;
    step(0, ins, '0, 0, 1, 0, 1, hs);
    check("t033_delivered", dir_chk, 1'b0);

    // ld.hu upper half: response lands while WB stalls and must come from the buffer.
    ins.lop = 5'b00001; ins.alu = 32'h0000_0002; ins.pc = 32'h1c00_0004;
    step(1, ins, 32'hBEEF_0000, 1, 1, 0, 0, hs);
    step(0, ins, '0, 0, 0, 0, 1, hs);
    check("t034_buffered", ms_to_ws_valid, 1'b1);
    step(0, ins, '0, 0, 0, 0, 0, hs);
    dir_exp = 32'h0000_BEEF; dir_chk = 1'b1;
    step(0, ins, '0, 0, 1, 0, 0, hs);
    check("t034_delivered", dir_chk, 1'b0);

    // Waiting load flushed alongside a cancelled EX request: two responses to drop.
    ins.lop = 5'b00100; ins.alu = 32'h0000_0040; ins.pc = 32'h1c00_0008;
    step(1, ins, 32'hAAAA_5555, 1, 1, 0, 0, hs);
    ins.pc = 32'h1c00_000c;
    step(1, ins, 32'h5555_AAAA, 1, 1, 1, 0, hs);
    check("t035_cnt2", ms_cancel_cnt, 3'd2);
    check("t036_full", ms_cancel_full, 1'b1);
    step(0, ins, '0, 0, 1, 0, 1, hs);
    check("t036_cnt1", ms_cancel_cnt, 3'd1);
    check("t036_not_full", ms_cancel_full, 1'b0);
    ins.alu = 32'h0000_0080; ins.pc = 32'h1c00_0010;
    step(1, ins, 32'h1234_5678, 1, 1, 0, 0, hs);
    dir_exp = 32'h1234_5678; dir_chk = 1'b1;
    step(0, ins, '0, 0, 1, 0, 1, hs);
    check("t035_not_early", dir_chk, 1'b1);
    step(0, ins, '0, 0, 1, 0, 1, hs);
    check("t035_delivered", dir_chk, 1'b0);

    // Excepting ld.w with no request: passes straight through with alu_result.
    ins = '0; ins.exc = 6'b000100; ins.lop = 5'b00100; ins.we = 1'b1; ins.dest = 5'd9;
    ins.alu = 32'hDEAD_0004; ins.pc = 32'h1c00_0014;
    step(1, ins, '0, 0, 1, 0, 0, hs);
    check("t037_ready", ms_to_ws_valid, 1'b1);
    dir_exp = 32'hDEAD_0004; dir_chk = 1'b1;
    step(0, ins, '0, 0, 1, 0, 0, hs);
    check("t037_delivered", dir_chk, 1'b0);

    // Randomized traffic; EX issues only while total outstanding requests < DEPTH.
    pres = 1'b0; pins = '0; pdat = '0;
    for (int n = 0; n < 3000; n++) begin
      issue = 1'b0;
      if (!pres && $urandom_range(0, 3) != 0) begin
        pins = '0;
        pins.pc = $urandom; pins.alu = $urandom;
        pins.dest = 5'($urandom); pins.we = 1'($urandom);
        pdat = $urandom;
        r = $urandom_range(0, 9);
        if (r <= 5 && mem_q.size() < DEPTH) begin
          pins.req = 1'b1;
          if (r <= 4) pins.lop = 5'(1 << $urandom_range(0, 4));
          issue = 1'b1;
        end else if (r == 6) begin
          pins.exc = 6'($urandom_range(1, 63));
          pins.lop = 5'(1 << $urandom_range(0, 4));
        end
        pres = 1'b1;
      end
      dok = mem_q.size() > 0 && mem_q[0].st != ST_EX && $urandom_range(0, 1) == 1;
      step(pres, pins, pdat, issue, $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, dok, hs);
      if (hs || flush) pres = 1'b0;
    end

    for (int c = 0; c < 400 && (pres || exp_q.size() > 0 || mem_q.size() > 0); c++) begin
      dok = mem_q.size() > 0 && mem_q[0].st != ST_EX;
      step(pres, pins, pdat, 0, 1, 0, dok, hs);
      if (hs) pres = 1'b0;
    end
    check("drain_empty", exp_q.size() + mem_q.size() + int'(pres), 0);

    // Reset while a load waits behind one pending discard.
    ins = '0; ins.lop = 5'b00100; ins.req = 1'b1; ins.we = 1'b1; ins.dest = 5'd7;
    step(1, ins, 32'h0BAD_0BAD, 1, 1, 0, 0, hs);
    step(0, ins, '0, 0, 1, 1, 0, hs);
    step(1, ins, 32'h600D_600D, 1, 1, 0, 0, hs);
    check("t038_cnt1", ms_cancel_cnt, 3'd1);
    es_to_ms_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("t038_cnt", ms_cancel_cnt, 3'd0);
    check("t038_full", ms_cancel_full, 1'b0);
    check("t038_valid", ms_to_ws_valid, 1'b0);
    check("t038_fwd", ms_fwd_bus[38:37], 2'b00);
    mem_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(0, ins, '0, 0, 1, 0, 0, hs);
      check("t038_idle", ms_to_ws_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_resp_stage.md
MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 Parameter EXC_W, default 6: width of exception flag field.
REQ-002 Parameter DEPTH, default 2: maximum number of cancelled in-flight data requests tracked (1..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 ws_allowin  input  1  WB can accept this cycle.
REQ-006 ms_allowin  output  1  MS can accept from EX this cycle.
REQ-007 es_to_ms_valid  input  1  EX holds a valid instruction for MS.
REQ-008 es_to_ms_bus  input  76+EXC_W  {exc_flg[EXC_W], req_issued, load_op[5], gr_we, dest[5], alu_result[32], pc[32]}, MSB first.
REQ-009 ms_to_ws_valid  output  1  MS instruction complete and valid for WB.
REQ-010 ms_to_ws_bus  output  70+EXC_W  {exc_flg, gr_we, dest, final_result[32], pc}, MSB first.
REQ-011 data_sram_data_ok  input  1  one read/write response returns this cycle (in order).
REQ-012 data_sram_rdata  input  32  response data, valid when data_ok=1.
REQ-013 flush  input  1  WB exception or ertn; kill MS contents.
REQ-014 es_req_cancel  input  1  EX instruction with an issued, unanswered request is being flushed this cycle.
REQ-015 ms_fwd_bus  output  39  {fwd_we, fwd_pending, dest[5], data[32]} to ID.
REQ-016 ms_cancel_cnt  output  3  current number of responses to discard.
REQ-017 ms_cancel_full  output  1  ms_cancel_cnt == DEPTH; EX shall not issue new requests.

Function
REQ-018 ms_valid SHALL load es_to_ms_valid when ms_allowin=1 and flush=0; bus register SHALL load only when es_to_ms_valid & ms_allowin.
REQ-019 flush=1 SHALL clear ms_valid and rbuf_valid next cycle, overriding any capture.
REQ-020 have_data = rbuf_valid | (data_sram_data_ok & cancel_cnt==0); ms_ready_go = !req_issued | have_data.
REQ-021 ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
REQ-022 data_ok with cancel_cnt==0, ms_valid=1, req_issued=1, rbuf_valid=0 and ws_allowin=0 SHALL latch rdata into rbuf, set rbuf_valid.
REQ-023 rbuf_valid SHALL clear when the instruction leaves MS (ms_to_ws_valid & ws_allowin).
REQ-024 data_ok with cancel_cnt>0 SHALL be discarded and decrement cancel_cnt by 1; it never reaches rbuf or final_result.
REQ-025 At flush: cancel_cnt += (ms_valid & req_issued & !have_data) + es_req_cancel, minus 1 if a discard occurs the same cycle; result saturates at DEPTH.
REQ-026 Load decode: load_op one-hot [4]ld.b [3]ld.h [2]ld.w [1]ld.bu [0]ld.hu; byte lane = alu_result[1:0]*8, half lane = alu_result[1]*16; signed for [4],[3].
REQ-027 final_result = alu_result if any exc_flg bit set or load_op==0, else extended load data from rbuf (if rbuf_valid) or data_sram_rdata.
REQ-028 fwd_we = ms_valid & gr_we; fwd_pending = ms_valid & gr_we & (|load_op) & !have_data; data = final_result.
REQ-029 Store with req_issued=1 SHALL also wait for data_ok; its response data is ignored.
REQ-030 Simultaneous data_ok and flush with cancel_cnt==0 SHALL consume the response for the flushed instruction (no cancel increment for it).

Reset
REQ-031 resetn=0 SHALL asynchronously clear ms_valid, rbuf_valid, cancel_cnt; ms_to_ws_valid=0, ms_cancel_cnt=0, ms_cancel_full=0, fwd_we=0, fwd_pending=0.
REQ-032 Reset mid-wait SHALL forget all outstanding requests (interconnect is reset concurrently).

Verification
REQ-033 ld.b, alu_result=0x1003, req_issued=1, data_ok one cycle later with rdata=0x80FF_FF00, ws_allowin=1 -> final_result=0xFFFF_FF80, ms_to_ws_valid on data_ok cycle.
REQ-034 ld.hu addr 0x2, data_ok while ws_allowin=0, rdata=0xBEEF_0000 -> rbuf holds it; ws_allowin=1 two cycles later -> final_result=0x0000_BEEF, rbuf_valid clears.
REQ-035 Load waiting + flush with es_req_cancel=1 -> cancel_cnt=2; next two data_ok discarded; new load's data_ok (third) delivered.
REQ-036 DEPTH=2, cancel_cnt=2 -> ms_cancel_full=1; one data_ok -> cnt=1, full=0.
REQ-037 exc_flg ALE set, load_op=ld.w, req_issued=0 -> ready_go=1 immediately, final_result=alu_result.
REQ-038 resetn low during wait with cancel_cnt=1 -> all state 0 asynchronously, no output valid after release.
